// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings,
// reset vector default and instruction length codes.
package instr_fetch_pkg;

    localparam logic [2:0] ST_ISSUE   = 3'd0;
    localparam logic [2:0] ST_OP      = 3'd1;
    localparam logic [2:0] ST_B2      = 3'd2;
    localparam logic [2:0] ST_B3      = 3'd3;
    localparam logic [2:0] ST_PRESENT = 3'd4;

    // Z8 reset vector
    localparam logic [11:0] DEFAULT_RESET_PC = 12'h00C;

    localparam logic [1:0] LEN_1 = 2'd1;
    localparam logic [1:0] LEN_2 = 2'd2;
    localparam logic [1:0] LEN_3 = 2'd3;

endpackage

// File: rtl/instr_fetch_length.sv
// Combinational Z8 opcode to instruction length (1..3 bytes) decoder,
// shared with the core's decoder checks.
module instr_length
    import instr_fetch_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [1:0] len
);

    always_comb begin
        len = LEN_2;
        case (opcode[3:0])
            4'hE, 4'hF:                     len = LEN_1;
            4'h4, 4'h5, 4'h6, 4'h7, 4'hD:   len = LEN_3;
            default:                        len = LEN_2;
        endcase
        // 0xD4 is the lone two-byte opcode in the n=4 column
        if (opcode == 8'hD4) begin
            len = LEN_2;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads opcode bytes from a synchronous ROM, assembles
// 1-3 byte Z8 instructions and hands them to the core over valid/ready.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 12,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [7:0]            rom_data,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [7:0]            instruction,
    output logic [7:0]            second,
    output logic [7:0]            third,
    output logic [1:0]            instr_len,
    output logic [ADDR_WIDTH-1:0] instr_pc
);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]            opcode_q, opcode_d;
    logic [7:0]            second_q, second_d;
    logic [7:0]            third_q, third_d;
    logic [1:0]            len_q, len_d;
    logic [1:0]            op_len;
    logic [ADDR_WIDTH-1:0] pc_plus_len;

    instr_length u_instr_length (
        .opcode (rom_data),
        .len    (op_len)
    );

    assign pc_plus_len = pc_q + ADDR_WIDTH'(len_q);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        opcode_d = opcode_q;
        second_d = second_q;
        third_d  = third_q;
        len_d    = len_q;
        case (state_q)
            ST_ISSUE: begin
                state_d = ST_OP;
            end
            ST_OP: begin
                opcode_d = rom_data;
                second_d = 8'h00;
                third_d  = 8'h00;
                len_d    = op_len;
                state_d  = (op_len == LEN_1) ? ST_PRESENT : ST_B2;
            end
            ST_B2: begin
                second_d = rom_data;
                state_d  = (len_q == LEN_2) ? ST_PRESENT : ST_B3;
            end
            ST_B3: begin
                third_d = rom_data;
                state_d = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (instr_ready) begin
                    pc_d    = pc_plus_len;
                    state_d = ST_OP;
                end
            end
            default: begin
                state_d = ST_ISSUE;
            end
        endcase
        // A redirect wins over everything, including a same-cycle accept
        if (jump_valid) begin
            pc_d     = jump_addr;
            state_d  = ST_ISSUE;
            opcode_d = 8'h00;
            second_d = 8'h00;
            third_d  = 8'h00;
            len_d    = LEN_1;
        end
    end

    // PRESENT already points at the next opcode so an accept goes straight to OP
    always_comb begin
        rom_addr = pc_q;
        case (state_q)
            ST_ISSUE: rom_addr = pc_q;
            ST_OP:    rom_addr = pc_q + ADDR_WIDTH'(1);
            ST_B2:    rom_addr = pc_q + ADDR_WIDTH'(2);
            default:  rom_addr = pc_plus_len;
        endcase
        if (!reset_n) begin
            rom_addr = RESET_PC;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_ISSUE;
            pc_q     <= RESET_PC;
            opcode_q <= 8'h00;
            second_q <= 8'h00;
            third_q  <= 8'h00;
            len_q    <= LEN_1;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            opcode_q <= opcode_d;
            second_q <= second_d;
            third_q  <= third_d;
            len_q    <= len_d;
        end
    end

    assign instr_valid = (state_q == ST_PRESENT);
    assign instruction = opcode_q;
    assign second      = second_q;
    assign third       = third_q;
    assign instr_len   = len_q;
    assign instr_pc    = pc_q;

endmodule
